// File: rtl/pipelined_chunk_adder.sv
// -----------------------------------------------------------------------------
// pipelined_chunk_adder
//
// Pipelined add/subtract unit. A WIDTH-bit operation is resolved CHUNK bits
// per pipeline stage (STAGES = WIDTH/CHUNK stages), with the ripple carry
// registered between stages. One operation per clock is accepted through a
// valid/ready handshake; the result appears STAGES clocks after acceptance,
// counting the accepting edge as the first. WIDTH must be a multiple of CHUNK.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operation offered
//   in_ready   unit can accept this cycle (combinational from out_ready)
//   a, b       operands
//   c_in       carry-in for add; ignored when sub=1
//   sub        0: a+b+c_in   1: a-b computed as a + ~b + 1
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result, modulo 2^WIDTH
//   c_out      carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        signed overflow
// -----------------------------------------------------------------------------
module pipelined_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  // The not-yet-added part of b_eff shrinks by CHUNK bits per stage, so the
  // per-stage remainders are packed back to back into one flat register:
  // stage k keeps WIDTH-(k+1)*CHUNK bits at offset k*WIDTH - CHUNK*k*(k+1)/2.
  // The last stage needs no remainder at all.
  localparam int BREM_RAW = (STAGES - 1) * WIDTH - (CHUNK * (STAGES - 1) * STAGES) / 2;
  localparam int BREM_W   = (BREM_RAW > 0) ? BREM_RAW : 1;

  logic                         adv;
  logic                         accept;
  logic [WIDTH-1:0]             b_eff;
  logic                         cin_eff;

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  // acc holds finished sum slices in its low bits and the still-unadded part
  // of operand a in its high bits; by the last stage it is the full sum.
  logic [STAGES-1:0][WIDTH-1:0] acc_q, acc_d;
  logic [BREM_W-1:0]            brem_q, brem_d;
  logic                         ovf_q, ovf_d;

  // Global stall: the whole pipe moves only when the output slot is free
  // or being drained this cycle.
  assign adv      = !valid_q[STAGES-1] || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub | c_in;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * CHUNK;
      localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << LO;

      logic [WIDTH-1:0] acc_in;
      logic [CHUNK-1:0] b_chunk;
      logic             cy_in;
      logic [CHUNK:0]   part;

      if (gi == 0) begin : g_first
        assign acc_in     = a;
        assign b_chunk    = b_eff[CHUNK-1:0];
        assign cy_in      = cin_eff;
        assign valid_d[0] = accept;
      end else begin : g_next
        localparam int OFF_PREV = (gi - 1) * WIDTH - (CHUNK * (gi - 1) * gi) / 2;
        assign acc_in      = acc_q[gi-1];
        assign b_chunk     = brem_q[OFF_PREV +: CHUNK];
        assign cy_in       = carry_q[gi-1];
        assign valid_d[gi] = valid_q[gi-1];
      end

      assign part        = {1'b0, acc_in[LO +: CHUNK]} + {1'b0, b_chunk} + (CHUNK+1)'(cy_in);
      assign acc_d[gi]   = (acc_in & ~MASK) | (WIDTH'(part[CHUNK-1:0]) << LO);
      assign carry_d[gi] = part[CHUNK];

      if (gi < STAGES - 1) begin : g_brem
        localparam int OFF = gi * WIDTH - (CHUNK * gi * (gi + 1)) / 2;
        localparam int RW  = WIDTH - (gi + 1) * CHUNK;
        if (gi == 0) begin : g_load
          assign brem_d[OFF +: RW] = b_eff[WIDTH-1:CHUNK];
        end else begin : g_pass
          localparam int OFF_PREV = (gi - 1) * WIDTH - (CHUNK * (gi - 1) * gi) / 2;
          // Drop the chunk consumed by this stage, keep the rest.
          assign brem_d[OFF +: RW] = brem_q[OFF_PREV + CHUNK +: RW];
        end
      end

      if (gi == STAGES - 1) begin : g_ovf
        // acc_in[MSB] is still operand a's MSB here; b_chunk[MSB] is b_eff's.
        assign ovf_d = (acc_in[WIDTH-1] == b_chunk[CHUNK-1]) &&
                       (acc_d[gi][WIDTH-1] != acc_in[WIDTH-1]);
      end
    end

    if (STAGES == 1) begin : g_no_brem
      assign brem_d = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      acc_q   <= '0;
      brem_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      brem_q  <= brem_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign c_out     = carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_chunk_adder
//
// Directed and randomized bench for pipelined_chunk_adder (WIDTH=16, CHUNK=4).
// Expected results come from plain integer arithmetic on the operands; a
// monitor pops them in acceptance order whenever a result is consumed.
// -----------------------------------------------------------------------------
module tb_pipelined_chunk_adder;
  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             c_in = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
  } exp_t;

  exp_t exp_q[$];
  logic acc_flag = 1'b0;

  always #5 clk = ~clk;

  pipelined_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: arithmetic on whole integers, overflow from the signed range.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input logic s);
    exp_t e;
    int ux, uy, sx, sy, sr, tot;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    if (s) begin
      tot  = ux - uy;
      e.co = (ux >= uy);
      sr   = sx - sy;
    end else begin
      tot  = ux + uy + int'(ci);
      e.co = tot[WIDTH];
      sr   = sx + sy + int'(ci);
    end
    e.s  = tot[WIDTH-1:0];
    e.ov = (sr > 32767) || (sr < -32768);
    return e;
  endfunction

  // Scoreboard monitor plus the holding rule under backpressure.
  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_sum = '0;
  logic             prev_co = 1'b0;
  logic             prev_ov = 1'b0;
  exp_t             mon_e;

  always @(negedge rst_n) prev_hold = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", sum, prev_sum);
        check("hold_c_out", c_out, prev_co);
        check("hold_ovf", ovf, prev_ov);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", out_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          n_out++;
          $display("out %0d: sum=%h c_out=%b ovf=%b (model sum=%h c_out=%b ovf=%b)",
                   n_out, sum, c_out, ovf, mon_e.s, mon_e.co, mon_e.ov);
          check("sb_sum", sum, mon_e.s);
          check("sb_c_out", c_out, mon_e.co);
          check("sb_ovf", ovf, mon_e.ov);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_sum  = sum;
      prev_co   = c_out;
      prev_ov   = ovf;
    end
  end

  task automatic drive(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic ci, input logic s);
    in_valid = v;
    a        = x;
    b        = y;
    c_in     = ci;
    sub      = s;
  endtask

  task automatic sample();
    @(negedge clk);
    acc_flag = in_valid && in_ready;
  endtask

  task automatic advance();
    @(posedge clk);
    if (acc_flag) exp_q.push_back(model(a, b, c_in, sub));
    acc_flag = 1'b0;
    #1;
  endtask

  // One op into an empty pipe; checks exact latency and the expected result.
  task automatic single_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic ci, input logic s,
                           input logic [WIDTH-1:0] es, input logic eco, input logic eov,
                           input string tag);
    drive(1'b1, x, y, ci, s);
    for (int t = 0; t <= STAGES; t++) begin
      sample();
      if (t < STAGES) begin
        check({tag, "_early_valid"}, out_valid, 0);
      end else begin
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_c_out"}, c_out, eco);
        check({tag, "_ovf"}, ovf, eov);
      end
      advance();
      if (t == 0) drive(1'b0, '0, '0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int idx, stall_cnt, vcount, start_n;
    logic started;
    logic [0:4] pat;
    logic exp_v;

    // ---------------- reset state ----------------
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_c_out", c_out, 0);
    check("reset_ovf", ovf, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sample();
    check("reset_in_ready", in_ready, 1);
    advance();

    // ---------------- directed single ops ----------------
    single_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "add_carry_chunk");
    single_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    single_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, "add_wrap");
    single_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    single_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");

    // ---------------- stream with 3-cycle stall ----------------
    idx = 1; stall_cnt = 0; started = 1'b0; vcount = 0; start_n = n_out;
    for (int cyc = 0; cyc < 60 && (idx <= 6 || exp_q.size() > 0); cyc++) begin
      if (idx <= 6) drive(1'b1, 16'(idx), 16'(idx * 'h1000), 1'b0, 1'b0);
      else          drive(1'b0, '0, '0, 1'b0, 1'b0);
      if (out_valid && !started) begin
        started   = 1'b1;
        stall_cnt = 3;
      end
      out_ready = (stall_cnt == 0);
      sample();
      if (out_valid) vcount++;
      if (stall_cnt > 0) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_sum", sum, 16'h1001);
        check("stall_valid", out_valid, 1);
        stall_cnt--;
      end
      if (acc_flag) idx++;
      advance();
    end
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("stream_pending", exp_q.size(), 0);
    check("stream_outputs", n_out - start_n, 6);
    check("stream_valid_cycles", vcount, 9);

    // ---------------- bubble pattern ----------------
    pat = 5'b10101;
    for (int t = 0; t < 10; t++) begin
      if (t < 5) drive(pat[t], 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
      else       drive(1'b0, '0, '0, 1'b0, 1'b0);
      sample();
      exp_v = 1'b0;
      if (t >= STAGES && t < STAGES + 5) exp_v = pat[t-STAGES];
      check("bubble_out_valid", out_valid, exp_v);
      advance();
    end

    // ---------------- random traffic with backpressure ----------------
    for (int t = 0; t < 120; t++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 2) != 0);
      sample();
      advance();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
      sample();
      advance();
    end
    check("random_drain", exp_q.size(), 0);

    // ---------------- asynchronous reset with ops in flight ----------------
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 16'(k * 'h0101), 16'(k * 'h0010), 1'b0, 1'b0);
      sample();
      advance();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_c_out", c_out, 0);
    check("async_rst_ovf", ovf, 0);
    exp_q.delete();
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      sample();
      check("post_reset_idle", out_valid, 0);
      advance();
    end
    single_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
